// File: rtl/store_merge_rmw.sv
// store_merge_rmw: SB/SH/SW store path to a word-wide memory without byte enables, using read-modify-write for partial stores.
// Define STORE_MISALIGN_TRAP_EN to reject misaligned SH/SW with err; otherwise the low address bits are ignored.
module store_merge_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              stall,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

    state_t            state, state_n;
    logic [2:0]        sel_q;
    logic [1:0]        off_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [31:0]       wdata_q, merged_q, merged;
    logic              rej_q, accept, illegal, misalign, reject;

    assign accept  = req_valid && req_ready;
    assign illegal = sel > 3'd2;
`ifdef STORE_MISALIGN_TRAP_EN
    assign misalign = (sel == 3'd1 && addr[0]) || (sel == 3'd2 && addr[1:0] != 2'b00);
    assign err      = rej_q;
`else
    assign misalign = 1'b0;
    assign err      = 1'b0;
`endif
    assign reject = illegal || misalign;

    assign req_ready = state == IDLE;
    assign stall     = !req_ready;
    assign mem_re    = state == READ;
    assign mem_we    = state == WRITE;
    assign done      = mem_we || rej_q;
    assign mem_addr  = {waddr_q, 2'b00};
    assign mem_wdata = sel_q == 3'd2 ? wdata_q : merged_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = accept && !reject ? (sel == 3'd2 ? WRITE : READ) : IDLE;
            READ:  state_n = MERGE;
            MERGE: state_n = WRITE;
            WRITE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // SH lane comes from addr[1] only, so an unchecked odd offset still lands on a half boundary
    always_comb begin
        merged = mem_rdata;
        if (sel_q == 3'd0)
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel_q    <= '0;
            off_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rej_q    <= 1'b0;
        end else begin
            state <= state_n;
            rej_q <= accept && reject;
            if (accept) begin
                sel_q   <= sel;
                off_q   <= addr[1:0];
                waddr_q <= addr[ADDR_W-1:2];
                wdata_q <= wdata;
            end
            if (state == MERGE)
                merged_q <= merged;
        end
    end
endmodule
